// File: rtl/wbcarbiter_x4.sv
// -----------------------------------------------------------------------------
// wbcarbiter_x4
//   Four-host to one-device Wishbone (classic) bus arbiter.
//
//   A round-robin search picks one requesting host while the arbiter is idle.
//   That host then owns the device port until it drops cyc. The device-side
//   request signals are combinational copies of the owner's request signals.
//   Device responses are steered back to the owner only. A stall watchdog
//   answers an error to the owner when the device leaves a strobed request
//   unanswered for TIMEOUT cycles.
//
//   Parameters
//     AW      address width (host and device side)
//     DW      data width
//     SW      byte-select width
//     TIMEOUT stall cycles before the arbiter answers err (8-bit counter)
//
//   Ports
//     clk, rst                      clock, synchronous active-low reset
//     wb_hostN_cyc/stb/we/addr/
//       wdata/sel       (in)        host N request, N = 0..3
//     wb_hostN_ack/err/rdata (out)  response to host N (zero unless N owns)
//     wb_dev_cyc/stb/we/addr/
//       wdata/sel       (out)       shared device request
//     wb_dev_ack/err/rdata   (in)   device response
// -----------------------------------------------------------------------------
module wbcarbiter_x4 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          wb_host0_cyc,
  input  logic          wb_host0_stb,
  input  logic          wb_host0_we,
  input  logic [AW-1:0] wb_host0_addr,
  input  logic [DW-1:0] wb_host0_wdata,
  input  logic [SW-1:0] wb_host0_sel,
  output logic          wb_host0_ack,
  output logic          wb_host0_err,
  output logic [DW-1:0] wb_host0_rdata,

  input  logic          wb_host1_cyc,
  input  logic          wb_host1_stb,
  input  logic          wb_host1_we,
  input  logic [AW-1:0] wb_host1_addr,
  input  logic [DW-1:0] wb_host1_wdata,
  input  logic [SW-1:0] wb_host1_sel,
  output logic          wb_host1_ack,
  output logic          wb_host1_err,
  output logic [DW-1:0] wb_host1_rdata,

  input  logic          wb_host2_cyc,
  input  logic          wb_host2_stb,
  input  logic          wb_host2_we,
  input  logic [AW-1:0] wb_host2_addr,
  input  logic [DW-1:0] wb_host2_wdata,
  input  logic [SW-1:0] wb_host2_sel,
  output logic          wb_host2_ack,
  output logic          wb_host2_err,
  output logic [DW-1:0] wb_host2_rdata,

  input  logic          wb_host3_cyc,
  input  logic          wb_host3_stb,
  input  logic          wb_host3_we,
  input  logic [AW-1:0] wb_host3_addr,
  input  logic [DW-1:0] wb_host3_wdata,
  input  logic [SW-1:0] wb_host3_sel,
  output logic          wb_host3_ack,
  output logic          wb_host3_err,
  output logic [DW-1:0] wb_host3_rdata,

  output logic          wb_dev_cyc,
  output logic          wb_dev_stb,
  output logic          wb_dev_we,
  output logic [AW-1:0] wb_dev_addr,
  output logic [DW-1:0] wb_dev_wdata,
  output logic [SW-1:0] wb_dev_sel,
  input  logic          wb_dev_ack,
  input  logic          wb_dev_err,
  input  logic [DW-1:0] wb_dev_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [7:0] stall_cnt;

  // Host requests gathered into indexable form.
  logic [3:0]    h_cyc;
  logic [3:0]    h_stb;
  logic [3:0]    h_we;
  logic [AW-1:0] h_addr  [4];
  logic [DW-1:0] h_wdata [4];
  logic [SW-1:0] h_sel   [4];

  assign h_cyc = {wb_host3_cyc, wb_host2_cyc, wb_host1_cyc, wb_host0_cyc};
  assign h_stb = {wb_host3_stb, wb_host2_stb, wb_host1_stb, wb_host0_stb};
  assign h_we  = {wb_host3_we,  wb_host2_we,  wb_host1_we,  wb_host0_we};

  assign h_addr[0]  = wb_host0_addr;
  assign h_addr[1]  = wb_host1_addr;
  assign h_addr[2]  = wb_host2_addr;
  assign h_addr[3]  = wb_host3_addr;
  assign h_wdata[0] = wb_host0_wdata;
  assign h_wdata[1] = wb_host1_wdata;
  assign h_wdata[2] = wb_host2_wdata;
  assign h_wdata[3] = wb_host3_wdata;
  assign h_sel[0]   = wb_host0_sel;
  assign h_sel[1]   = wb_host1_sel;
  assign h_sel[2]   = wb_host2_sel;
  assign h_sel[3]   = wb_host3_sel;

  // Round-robin pick: first requester at or after 'start', wrapping mod 4.
  // Returns {found, index}. Scanning from the far end lets the nearest
  // requester overwrite earlier hits.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  logic [2:0] pick;
  logic       grant_any;
  logic [1:0] grant_idx;

  assign pick      = rr_pick(h_cyc, ptr);
  assign grant_any = pick[2];
  assign grant_idx = pick[1:0];

  logic owned;
  assign owned = (state == OWNED);

  // Device request mux: the owner's signals pass straight through.
  always_comb begin
    wb_dev_cyc   = 1'b0;
    wb_dev_stb   = 1'b0;
    wb_dev_we    = 1'b0;
    wb_dev_addr  = '0;
    wb_dev_wdata = '0;
    wb_dev_sel   = '0;
    if (owned) begin
      wb_dev_cyc   = h_cyc[owner];
      wb_dev_stb   = h_stb[owner];
      wb_dev_we    = h_we[owner];
      wb_dev_addr  = h_addr[owner];
      wb_dev_wdata = h_wdata[owner];
      wb_dev_sel   = h_sel[owner];
    end
  end

  // Watchdog fires only on a strobed, unanswered cycle.
  logic timeout_pulse;
  logic owner_err;
  logic owner_ack;

  assign timeout_pulse = owned && wb_dev_stb && (stall_cnt == TIMEOUT_CNT) &&
                         !wb_dev_ack && !wb_dev_err;
  assign owner_err     = wb_dev_err | timeout_pulse;
  // Error wins over a simultaneous acknowledge.
  assign owner_ack     = wb_dev_ack & ~owner_err;

  // Response demux: only the owner ever sees ack/err/rdata.
  logic [3:0]    ack_v;
  logic [3:0]    err_v;
  logic [DW-1:0] rdata_v [4];

  always_comb begin
    ack_v   = '0;
    err_v   = '0;
    rdata_v = '{default: '0};
    if (owned) begin
      ack_v[owner]   = owner_ack;
      err_v[owner]   = owner_err;
      rdata_v[owner] = wb_dev_rdata;
    end
  end

  assign wb_host0_ack   = ack_v[0];
  assign wb_host1_ack   = ack_v[1];
  assign wb_host2_ack   = ack_v[2];
  assign wb_host3_ack   = ack_v[3];
  assign wb_host0_err   = err_v[0];
  assign wb_host1_err   = err_v[1];
  assign wb_host2_err   = err_v[2];
  assign wb_host3_err   = err_v[3];
  assign wb_host0_rdata = rdata_v[0];
  assign wb_host1_rdata = rdata_v[1];
  assign wb_host2_rdata = rdata_v[2];
  assign wb_host3_rdata = rdata_v[3];

  // Ownership FSM plus stall watchdog. Ownership ends only when the owner
  // drops cyc, so the pointer advance happens there. The dead IDLE cycle
  // that follows is where the next owner is chosen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      stall_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state <= OWNED;
            owner <= grant_idx;
          end
        end
        OWNED: begin
          if (!h_cyc[owner]) begin
            state <= IDLE;
            ptr   <= owner + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (!owned || !wb_dev_stb || wb_dev_ack || wb_dev_err || timeout_pulse)
        stall_cnt <= 8'd0;
      else
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wbcarbiter_x4.sv
// -----------------------------------------------------------------------------
// tb_wbcarbiter_x4
//   Four randomised Wishbone hosts and a scripted device drive the arbiter.
//   Every started transaction pushes its expected outcome into a per-host
//   queue; a negedge monitor pops and compares on every host ack/err and,
//   through a small ownership model, checks the device-side mux, the
//   non-owner silence and the round-robin grant order each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbcarbiter_x4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_TMO = 3;

  logic clk = 1'b0;
  logic rst;

  logic          h_cyc [4];
  logic          h_stb [4];
  logic          h_we  [4];
  logic [AW-1:0] h_addr  [4];
  logic [DW-1:0] h_wdata [4];
  logic [SW-1:0] h_sel   [4];
  logic          o_ack [4];
  logic          o_err [4];
  logic [DW-1:0] o_rdata [4];

  logic          dev_cyc, dev_stb, dev_we;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic [SW-1:0] dev_sel;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;

  wbcarbiter_x4 #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .wb_host0_cyc(h_cyc[0]), .wb_host0_stb(h_stb[0]), .wb_host0_we(h_we[0]),
    .wb_host0_addr(h_addr[0]), .wb_host0_wdata(h_wdata[0]), .wb_host0_sel(h_sel[0]),
    .wb_host0_ack(o_ack[0]), .wb_host0_err(o_err[0]), .wb_host0_rdata(o_rdata[0]),
    .wb_host1_cyc(h_cyc[1]), .wb_host1_stb(h_stb[1]), .wb_host1_we(h_we[1]),
    .wb_host1_addr(h_addr[1]), .wb_host1_wdata(h_wdata[1]), .wb_host1_sel(h_sel[1]),
    .wb_host1_ack(o_ack[1]), .wb_host1_err(o_err[1]), .wb_host1_rdata(o_rdata[1]),
    .wb_host2_cyc(h_cyc[2]), .wb_host2_stb(h_stb[2]), .wb_host2_we(h_we[2]),
    .wb_host2_addr(h_addr[2]), .wb_host2_wdata(h_wdata[2]), .wb_host2_sel(h_sel[2]),
    .wb_host2_ack(o_ack[2]), .wb_host2_err(o_err[2]), .wb_host2_rdata(o_rdata[2]),
    .wb_host3_cyc(h_cyc[3]), .wb_host3_stb(h_stb[3]), .wb_host3_we(h_we[3]),
    .wb_host3_addr(h_addr[3]), .wb_host3_wdata(h_wdata[3]), .wb_host3_sel(h_sel[3]),
    .wb_host3_ack(o_ack[3]), .wb_host3_err(o_err[3]), .wb_host3_rdata(o_rdata[3]),
    .wb_dev_cyc(dev_cyc), .wb_dev_stb(dev_stb), .wb_dev_we(dev_we),
    .wb_dev_addr(dev_addr), .wb_dev_wdata(dev_wdata), .wb_dev_sel(dev_sel),
    .wb_dev_ack(d_ack), .wb_dev_err(d_err), .wb_dev_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome per transaction.
  typedef struct packed {
    logic          err;
    logic          tmo;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q [4][$];

  // Device plan for each host's current transaction.
  int            p_kind [4];
  int            p_lat  [4];
  logic [DW-1:0] p_rdata [4];
  bit            p_drop [4];

  bit h_active [4];
  int h_gap  [4];
  int h_left [4];
  int seq = 0;
  int tmo_left = 4;
  int dev_wait = 0;

  task automatic start_txn(input int h, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] sel,
                           input int kind, input int lat, input logic [DW-1:0] rdata,
                           input bit drop);
    exp_t e;
    h_cyc[h] = 1'b1; h_stb[h] = 1'b1; h_we[h] = we;
    h_addr[h] = addr; h_wdata[h] = wdata; h_sel[h] = sel;
    p_kind[h] = kind; p_lat[h] = lat; p_rdata[h] = rdata; p_drop[h] = drop;
    h_active[h] = 1'b1;
    e.err = (kind != K_ACK);
    e.tmo = (kind == K_TMO);
    e.rdata = rdata;
    exp_q[h].push_back(e);
  endtask

  task automatic rand_txn(input int h);
    int r, kind;
    logic [AW-1:0] a;
    r = $urandom_range(0, 99);
    if (r < 2 && tmo_left > 0) begin kind = K_TMO; tmo_left--; end
    else if (r < 14) kind = K_ERR;
    else if (r < 22) kind = K_BOTH;
    else kind = K_ACK;
    a = AW'(seq);
    a[AW-1 -: 4] = 4'(h + 1);
    seq++;
    start_txn(h, 1'($urandom_range(0, 1)), a, $urandom, SW'($urandom_range(0, 15)),
              kind, $urandom_range(0, 4), $urandom,
              (kind != K_TMO) && ($urandom_range(0, 9) == 0));
  endtask

  // One clock: sample at negedge, then drive device and hosts after posedge.
  task automatic step();
    logic s_cyc, s_stb, resp;
    logic [AW-1:0] s_addr;
    logic s_ack [4];
    logic s_err [4];
    int hh;
    @(negedge clk);
    s_cyc = dev_cyc; s_stb = dev_stb; s_addr = dev_addr;
    for (int h = 0; h < 4; h++) begin s_ack[h] = o_ack[h]; s_err[h] = o_err[h]; end
    @(posedge clk); #1;
    resp = d_ack | d_err;
    d_ack = 1'b0; d_err = 1'b0; d_rdata = $urandom;
    if (s_cyc && s_stb && !resp) begin
      hh = -1;
      for (int h = 0; h < 4; h++) if (h_active[h] && h_addr[h] == s_addr) hh = h;
      dev_wait++;
      if (hh >= 0 && p_kind[hh] != K_TMO && dev_wait > p_lat[hh]) begin
        d_ack = (p_kind[hh] == K_ACK) || (p_kind[hh] == K_BOTH);
        d_err = (p_kind[hh] == K_ERR) || (p_kind[hh] == K_BOTH);
        d_rdata = p_rdata[hh];
        dev_wait = 0;
        if (p_drop[hh]) begin h_cyc[hh] = 1'b0; h_stb[hh] = 1'b0; end
      end
    end else begin
      dev_wait = 0;
    end
    for (int h = 0; h < 4; h++) begin
      if (h_active[h]) begin
        if (s_ack[h] || s_err[h]) begin
          h_active[h] = 1'b0; h_cyc[h] = 1'b0; h_stb[h] = 1'b0;
          h_gap[h] = $urandom_range(0, 3);
        end
      end else if (h_gap[h] > 0) begin
        h_gap[h]--;
      end else if (h_left[h] > 0) begin
        h_left[h]--;
        rand_txn(h);
      end
    end
  endtask

  function automatic bit all_done();
    all_done = 1'b1;
    for (int h = 0; h < 4; h++) if (h_active[h] || h_left[h] > 0) all_done = 1'b0;
  endfunction

  task automatic run_drain(input string name, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin step(); n++; end
    check(name, 64'(all_done()), 64'd1);
  endtask

  // ---------------- monitor: ownership model + scoreboard ----------------
  bit   m_owned = 1'b0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  int   stall_obs = 0;
  int   nrsp;
  int   grant_log[$];
  exp_t e_mon;

  always @(negedge clk) begin
    if (m_owned) begin
      check("dev_cyc",   dev_cyc,   h_cyc[m_owner]);
      check("dev_stb",   dev_stb,   h_stb[m_owner]);
      check("dev_we",    dev_we,    h_we[m_owner]);
      check("dev_addr",  dev_addr,  h_addr[m_owner]);
      check("dev_wdata", dev_wdata, h_wdata[m_owner]);
      check("dev_sel",   dev_sel,   h_sel[m_owner]);
      for (int h = 0; h < 4; h++)
        if (h != m_owner) check("nonowner_quiet", {o_ack[h], o_err[h], o_rdata[h]}, 64'd0);
      if (h_stb[m_owner]) stall_obs++; else stall_obs = 0;
    end else begin
      check("idle_dev_ctl",   {dev_cyc, dev_stb, dev_we, dev_sel}, 64'd0);
      check("idle_dev_addr",  dev_addr, 64'd0);
      check("idle_dev_wdata", dev_wdata, 64'd0);
      for (int h = 0; h < 4; h++) check("idle_rsp", {o_ack[h], o_err[h]}, 64'd0);
      stall_obs = 0;
    end

    nrsp = 0;
    for (int h = 0; h < 4; h++) begin
      if (o_ack[h] || o_err[h]) begin
        nrsp++;
        if (exp_q[h].size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: host %0d got ack=%0b err=%0b, required none (t=%0t)",
                   h, o_ack[h], o_err[h], $time);
        end else begin
          e_mon = exp_q[h].pop_front();
          check("rsp_err", o_err[h], e_mon.err);
          check("rsp_ack", o_ack[h], !e_mon.err);
          if (!e_mon.err) check("rsp_rdata", o_rdata[h], e_mon.rdata);
          if (e_mon.tmo) check("tmo_cycles", 64'(stall_obs), 64'd256);
        end
        stall_obs = 0;
      end
    end
    if (nrsp > 0) check("single_rsp", 64'(nrsp), 64'd1);

    // advance the model to the next cycle
    if (!rst) begin
      m_owned = 1'b0; m_ptr = 0;
    end else if (!m_owned) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_owned && h_cyc[(m_ptr + k) % 4]) begin
          m_owned = 1'b1; m_owner = (m_ptr + k) % 4;
          grant_log.push_back(m_owner);
        end
      end
    end else if (!h_cyc[m_owner]) begin
      m_owned = 1'b0; m_ptr = (m_owner + 1) % 4;
    end
  end

  // ---------------- stimulus ----------------
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0;
    d_ack = 1'b0; d_err = 1'b0; d_rdata = '0;
    for (int h = 0; h < 4; h++) begin
      h_cyc[h] = 1'b0; h_stb[h] = 1'b0; h_we[h] = 1'b0;
      h_addr[h] = '0; h_wdata[h] = '0; h_sel[h] = '0;
      h_active[h] = 1'b0; h_gap[h] = 0; h_left[h] = 0;
      p_kind[h] = K_ACK; p_lat[h] = 0; p_rdata[h] = '0; p_drop[h] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b1;

    // single write from host2
    start_txn(2, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, K_ACK, 2, 32'h1234_5678, 1'b0);
    run_drain("drain_single", 100);

    // simultaneous ack+err
    start_txn(1, 1'b0, 32'h20, 32'h0, 4'hF, K_BOTH, 1, 32'hDEAD_BEEF, 1'b0);
    run_drain("drain_both", 100);

    // timeout on host0 while host1 is held off
    start_txn(0, 1'b0, 32'h30, 32'h0, 4'hF, K_TMO, 0, 32'h0, 1'b0);
    repeat (3) step();
    start_txn(1, 1'b1, 32'h40, 32'h5555_AAAA, 4'h3, K_ACK, 0, 32'h0BAD_F00D, 1'b0);
    run_drain("drain_tmo", 600);

    // owner drops cyc in the same cycle the device acks
    start_txn(3, 1'b0, 32'h50, 32'h0, 4'hF, K_ACK, 1, 32'hCAFE_0001, 1'b1);
    run_drain("drain_drop", 100);

    // round robin from reset: all four request together, host0 comes back
    rst = 1'b0; step(); rst = 1'b1;
    grant_log.delete();
    for (int h = 0; h < 4; h++)
      start_txn(h, 1'b0, 32'h100 + 32'(h), 32'h0, 4'hF, K_ACK, 0, 32'h7000 + 32'(h), 1'b0);
    h_left[0] = 1;
    run_drain("drain_rr", 200);
    check("rr_order_len", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("rr_order", 64'(grant_log[k]), 64'(rr_exp[k]));

    // randomized traffic
    for (int h = 0; h < 4; h++) h_left[h] = 25;
    run_drain("drain_random", 20000);

    // reset while host3 owns, pointer pushed to 2 beforehand
    start_txn(1, 1'b0, 32'h60, 32'h0, 4'hF, K_ACK, 0, 32'h11, 1'b0);
    run_drain("drain_pre_rst", 100);
    start_txn(3, 1'b0, 32'h70, 32'h0, 4'hF, K_TMO, 0, 32'h0, 1'b0);
    repeat (4) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int h = 0; h < 4; h++) begin
      h_active[h] = 1'b0; h_cyc[h] = 1'b0; h_stb[h] = 1'b0;
      exp_q[h].delete();
    end
    dev_wait = 0;
    step();
    grant_log.delete();
    for (int h = 1; h < 4; h++)
      start_txn(h, 1'b1, 32'h200 + 32'(h), 32'(h), 4'hF, K_ACK, 1, 32'h9000 + 32'(h), 1'b0);
    run_drain("drain_post_rst", 200);
    check("post_rst_len", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() > 0) check("post_rst_first_grant", 64'(grant_log[0]), 64'd1);

    repeat (2) step();
    for (int h = 0; h < 4; h++) check("q_empty", 64'(exp_q[h].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
